// File: rtl/program_loader.sv
// program_loader: byte-stream command parser driving the shader core's ext_write_* load port and run enable.
// Define LOADER_CHECKSUM_EN to require a trailing checksum byte on WRITE packets.
module program_loader #(
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [ADDRESS_WIDTH-1:0] ext_write_address,
    output logic [31:0]              ext_write_data,
    output logic                     ext_enable_write_inst,
    output logic                     ext_enable_write_data,
    output logic                     run,
    input  logic                     halted,
    output logic                     busy,
    output logic                     cmd_error,
    output logic                     checksum_error
);
    typedef enum logic [2:0] {
        IDLE, ADDR0, ADDR1, CNT0, CNT1, DATA,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        RUNNING
    } state_t;
`ifdef LOADER_CHECKSUM_EN
    localparam state_t DONE = CSUM;
    logic [7:0] sum;
`else
    localparam state_t DONE = IDLE;
    assign checksum_error = 1'b0;
`endif
    state_t state;
    logic target_data;
    logic [7:0] addr_lo, cnt_lo;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [15:0] count;
    logic [1:0] idx;
    logic [23:0] word;
    logic accept, unused_halted;
    assign in_ready = !reset && !ext_enable_write_inst && !ext_enable_write_data;
    assign accept = in_valid && in_ready;
    assign busy = state != IDLE && state != RUNNING;
    assign unused_halted = halted;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            run <= 1'b0;
            ext_enable_write_inst <= 1'b0;
            ext_enable_write_data <= 1'b0;
            ext_write_address <= '0;
            ext_write_data <= '0;
            cmd_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum_error <= 1'b0;
            sum <= '0;
`endif
            target_data <= 1'b0;
            addr_lo <= '0;
            cnt_lo <= '0;
            address <= '0;
            count <= '0;
            idx <= '0;
            word <= '0;
        end else begin
            ext_enable_write_inst <= 1'b0;
            ext_enable_write_data <= 1'b0;
            if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                if (state inside {ADDR0, ADDR1, CNT0, CNT1, DATA}) sum <= sum + in_data;
`endif
                case (state)
                    IDLE: begin
                        if (in_data == 8'h01 || in_data == 8'h02) begin
                            target_data <= in_data == 8'h02;
`ifdef LOADER_CHECKSUM_EN
                            sum <= '0;
`endif
                            state <= ADDR0;
                        end else if (in_data == 8'h03) begin
                            run <= 1'b1;
                            state <= RUNNING;
                        end else if (in_data == 8'h05) begin
                            cmd_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                            checksum_error <= 1'b0;
`endif
                        end else if (in_data != 8'h04) begin
                            cmd_error <= 1'b1;
                        end
                    end
                    ADDR0: begin
                        addr_lo <= in_data;
                        state <= ADDR1;
                    end
                    ADDR1: begin
                        address <= ADDRESS_WIDTH'({in_data, addr_lo});
                        state <= CNT0;
                    end
                    CNT0: begin
                        cnt_lo <= in_data;
                        state <= CNT1;
                    end
                    CNT1: begin
                        count <= {in_data, cnt_lo};
                        idx <= '0;
                        state <= {in_data, cnt_lo} == 16'd0 ? DONE : DATA;
                    end
                    DATA: begin
                        word <= {in_data, word[23:8]};
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            ext_write_address <= address;
                            ext_write_data <= {in_data, word};
                            ext_enable_write_inst <= !target_data;
                            ext_enable_write_data <= target_data;
                            address <= address + ADDRESS_WIDTH'(4);
                            count <= count - 16'd1;
                            if (count == 16'd1) state <= DONE;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    CSUM: begin
                        if (in_data != sum) checksum_error <= 1'b1;
                        state <= IDLE;
                    end
`endif
                    RUNNING: begin
                        if (in_data == 8'h04) begin
                            run <= 1'b0;
                            state <= IDLE;
                        end else if (in_data == 8'h05) begin
                            cmd_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                            checksum_error <= 1'b0;
`endif
                        end else begin
                            cmd_error <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader; expected writes are queued as packets are sent.
module tb_program_loader;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] ext_write_address;
    logic [31:0] ext_write_data;
    logic        ext_enable_write_inst, ext_enable_write_data;
    logic        run, busy, cmd_error, checksum_error;
    logic        halted = 1'b0;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        inst;
        logic [15:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    program_loader #(.ADDRESS_WIDTH(16)) dut (
        .clock(clock),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ext_write_address(ext_write_address),
        .ext_write_data(ext_write_data),
        .ext_enable_write_inst(ext_enable_write_inst),
        .ext_enable_write_data(ext_enable_write_data),
        .run(run),
        .halted(halted),
        .busy(busy),
        .cmd_error(cmd_error),
        .checksum_error(checksum_error)
    );

    always #5 clock = ~clock;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clock) begin
        if (ext_enable_write_inst || ext_enable_write_data) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {ext_enable_write_inst, ext_enable_write_data}, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe",
                      {ext_enable_write_inst, ext_enable_write_data, ext_write_address, ext_write_data, in_ready},
                      {e.inst, !e.inst, e.addr, e.data, 1'b0});
            end
        end
    end

    task automatic expect_write(input logic inst, input logic [15:0] addr, input logic [31:0] data);
        exp_t e;
        e.inst = inst;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        in_data = b;
        in_valid = 1'b1;
        for (int n = 0; n < 20 && !acc; n++) begin
            acc = in_ready;
            @(negedge clock);
        end
        in_valid = 1'b0;
        check("handshake", acc, 1);
    endtask

    task automatic send_seq(input logic [127:0] bytes, input int n);
        for (int i = n - 1; i >= 0; i--) send(bytes[8*i +: 8]);
    endtask

    task automatic send_pkt(input logic [127:0] bytes, input int n, input logic [7:0] csum);
        send_seq(bytes, n);
`ifdef LOADER_CHECKSUM_EN
        send(csum);
`endif
    endtask

    task automatic settle();
        repeat (2) @(negedge clock);
    endtask

    initial begin
        logic exp_csum_err;
        repeat (3) @(negedge clock);
        check("reset_in_ready", in_ready, 0);
        check("reset_outputs", {run, ext_enable_write_inst, ext_enable_write_data, busy, cmd_error, checksum_error}, 0);
        check("reset_bus", {ext_write_address, ext_write_data}, 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_in_ready", in_ready, 1);

        expect_write(1'b1, 16'h0000, 32'h00100513);
        send_pkt({8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00}, 9, 8'h29);
        settle();
        check("pkt1_busy", busy, 0);
        check("pkt1_flags", {cmd_error, checksum_error}, 0);
        check("pkt1_hold", {ext_write_address, ext_write_data}, {16'h0000, 32'h00100513});

        expect_write(1'b0, 16'hFFFC, 32'hAABBCCDD);
        expect_write(1'b0, 16'h0000, 32'h11223344);
        send_pkt({8'h02, 8'hFC, 8'hFF, 8'h02, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA,
                  8'h44, 8'h33, 8'h22, 8'h11}, 13, 8'hB5);
        settle();
        check("pkt2_busy", busy, 0);
        check("pkt2_pending", exp_q.size(), 0);

        expect_write(1'b1, 16'h0000, 32'h0);
        exp_q.pop_back();
        send_pkt({8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 5, 8'h00);
        settle();
        check("count0_busy", busy, 0);

        send(8'h03);
        check("run_rise", run, 1);
        check("run_busy", busy, 0);
        send(8'h01);
        check("run_bad_cmd", {run, cmd_error}, 2'b11);
        send(8'h05);
        check("run_clear", {run, cmd_error}, 2'b10);
        send(8'h04);
        check("run_fall", {run, busy}, 0);

        send(8'h7F);
        check("stray_cmd_error", cmd_error, 1);
        expect_write(1'b1, 16'h0010, 32'hDEADBEEF);
        send_pkt({8'h01, 8'h10, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 9, 8'h49);
        settle();
        check("stray_sticky", cmd_error, 1);
        send(8'h05);
        check("stray_cleared", cmd_error, 0);

        send_seq({8'h02, 8'h20, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22}, 7);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_reset_in_ready", in_ready, 0);
        reset = 1'b0;
        @(negedge clock);
        check("mid_after", {busy, run, in_ready}, 3'b001);
        expect_write(1'b0, 16'h0020, 32'h44332211);
        send_pkt({8'h02, 8'h20, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44}, 9, 8'hCB);
        settle();
        check("mid_fresh_pending", exp_q.size(), 0);

        send(8'h03);
        check("run_before_reset", run, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("run_after_reset", {run, busy}, 0);

`ifdef LOADER_CHECKSUM_EN
        exp_csum_err = 1'b1;
`else
        exp_csum_err = 1'b0;
`endif
        expect_write(1'b1, 16'h0000, 32'h00100513);
        send_pkt({8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00}, 9, 8'h2A);
        settle();
        check("csum_error", checksum_error, exp_csum_err);
        check("csum_busy", busy, 0);
        send(8'h05);
        check("csum_cleared", {checksum_error, cmd_error}, 0);

        settle();
        check("final_pending", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
